// File: rtl/l2_snoop_nexus.sv
// L2 line store with a fixed-latency fill FSM and a one-entry eviction write buffer.
// Define L2_NEXUS_STATS_EN to build the read/evict/retry event counters.
module l2_snoop_nexus #(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_valid,
    input  logic [31:0]  req_addr,
    input  logic         evict_wren,
    input  logic [127:0] evict_line,
    input  logic         hold_off,
    output logic [127:0] fill_line,
    output logic         fill_valid,
    output logic         busy,
    output logic [15:0]  stat_reads,
    output logic [15:0]  stat_evicts,
    output logic [15:0]  stat_retries
);
    typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic [LINE_BITS-1:0] req_idx;
    logic [LINE_BITS-1:0] rd_idx;
    logic                 wbuf_vld;
    logic [LINE_BITS-1:0] wbuf_idx;
    logic [127:0]         wbuf_data;
    logic [127:0]         store [0:(1<<LINE_BITS)-1];
    logic [127:0]         store_rd;
    logic                 unused_addr;

    // Only the index bits are kept; everything above aliases onto the same line.
    assign req_idx     = req_addr[LINE_BITS+3:4];
    assign unused_addr = ^{req_addr[31:LINE_BITS+4], req_addr[3:0]};

    // Backing store deliberately has no reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (wbuf_vld)
            store[wbuf_idx] <= wbuf_data;
    end

    // A pending entry drains on every edge, so a back-to-back eviction just replaces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbuf_vld  <= 1'b0;
            wbuf_idx  <= '0;
            wbuf_data <= '0;
        end else begin
            wbuf_vld <= evict_wren;
            if (evict_wren) begin
                wbuf_idx  <= req_idx;
                wbuf_data <= evict_line;
            end
        end
    end

    // Newest write wins: an eviction landing this edge beats the draining buffer, which beats the store.
    always_comb begin
        store_rd = store[rd_idx];
        if (wbuf_vld && wbuf_idx == rd_idx)
            store_rd = wbuf_data;
        if (evict_wren && req_idx == rd_idx)
            store_rd = evict_line;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_idx     <= '0;
            fill_line  <= '0;
            fill_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_valid) begin
                    rd_idx <= req_idx;
                    cnt    <= CNT_INIT;
                    busy   <= 1'b1;
                    state  <= WAIT;
                end
                WAIT: if (cnt == 8'd0) begin
                    fill_line  <= store_rd;
                    fill_valid <= 1'b1;
                    state      <= FILL;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                FILL: if (!hold_off) begin
                    fill_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    fill_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef L2_NEXUS_STATS_EN
    logic rd_accept;
    assign rd_accept = (state == IDLE) && rd_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads   <= '0;
            stat_evicts  <= '0;
            stat_retries <= '0;
        end else begin
            if (rd_accept)
                stat_reads <= stat_reads + 16'd1;
            if (evict_wren)
                stat_evicts <= stat_evicts + 16'd1;
            if (state == FILL && hold_off)
                stat_retries <= stat_retries + 16'd1;
        end
    end
`else
    assign stat_reads   = '0;
    assign stat_evicts  = '0;
    assign stat_retries = '0;
`endif

endmodule

// File: tb/tb_l2_snoop_nexus.sv
// Bench for l2_snoop_nexus: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_l2_snoop_nexus;
    localparam int LAT = 4;
`ifdef L2_NEXUS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_valid;
    logic [31:0]  req_addr;
    logic         evict_wren;
    logic [127:0] evict_line;
    logic         hold_off;
    logic [127:0] fill_line;
    logic         fill_valid;
    logic         busy;
    logic [15:0]  stat_reads, stat_evicts, stat_retries;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_snoop_nexus #(.LATENCY(LAT), .LINE_BITS(10)) dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .req_addr(req_addr),
        .evict_wren(evict_wren), .evict_line(evict_line), .hold_off(hold_off),
        .fill_line(fill_line), .fill_valid(fill_valid), .busy(busy),
        .stat_reads(stat_reads), .stat_evicts(stat_evicts), .stat_retries(stat_retries)
    );

    function automatic logic [15:0] sv(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rd_valid = 1'b0; evict_wren = 1'b0; hold_off = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic evict(input logic [31:0] a, input logic [127:0] d);
        req_addr = a; evict_line = d; evict_wren = 1'b1;
        tick();
        evict_wren = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] d;
        idle_in(); req_addr = '0; evict_line = '0;
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL reset_fill_valid got=%0b exp=0", fill_valid); end
        checks++; if (fill_line !== '0) begin failures++; $display("FAIL reset_fill_line got=%h exp=0", fill_line); end
        checks++; if ({stat_reads, stat_evicts, stat_retries} !== '0) begin failures++; $display("FAIL reset_stats got=%h/%h/%h exp=0", stat_reads, stat_evicts, stat_retries); end
        reset = 1'b0;
        // park a read in FILL under hold_off, then reset asynchronously mid-cycle
        d = rand128();
        evict(32'h30, d);
        rd_valid = 1'b1; req_addr = 32'h30; hold_off = 1'b1;
        for (int k = 0; k < 6; k++) begin tick(); rd_valid = 1'b0; end
        checks++; if (fill_valid !== 1'b1 || fill_line !== d) begin failures++; $display("FAIL pre_reset_fill got=%0b/%h exp=1/%h", fill_valid, fill_line, d); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || fill_valid !== 1'b0) begin failures++; $display("FAIL async_reset_ctl got=%0b/%0b exp=0/0", busy, fill_valid); end
        checks++; if (fill_line !== '0) begin failures++; $display("FAIL async_reset_line got=%h exp=0", fill_line); end
        checks++; if ({stat_reads, stat_evicts, stat_retries} !== '0) begin failures++; $display("FAIL async_reset_stats got=%h/%h/%h exp=0", stat_reads, stat_evicts, stat_retries); end
        tick();
        reset = 1'b0; hold_off = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        evict(32'h0000_1230, {16{8'hAA}});
        for (int k = 0; k < 9; k++) tick();
        rd_valid = 1'b1; req_addr = 32'h0000_1234;
        for (int k = 0; k <= 7; k++) begin
            checks++; if (fill_valid !== (k == 5)) begin failures++; $display("FAIL basic_fill_valid c%0d got=%0b exp=%0b", k, fill_valid, k == 5); end
            checks++; if (busy !== (k >= 1 && k <= 5)) begin failures++; $display("FAIL basic_busy c%0d got=%0b exp=%0b", k, busy, k >= 1 && k <= 5); end
            if (k == 5) begin
                checks++; if (fill_line !== {16{8'hAA}}) begin failures++; $display("FAIL basic_fill_line got=%h exp=%h", fill_line, {16{8'hAA}}); end
            end
            tick(); rd_valid = 1'b0;
        end
        checks++; if (stat_reads !== sv(1) || stat_evicts !== sv(1)) begin failures++; $display("FAIL basic_stats got=%0d/%0d exp=%0d/%0d", stat_reads, stat_evicts, sv(1), sv(1)); end
    endtask

    task automatic test_retry();
        logic [127:0] d;
        do_reset();
        d = rand128();
        evict(32'h500, d);
        tick();
        rd_valid = 1'b1; req_addr = 32'h500;
        for (int k = 0; k <= 10; k++) begin
            checks++; if (fill_valid !== (k >= 5 && k <= 8)) begin failures++; $display("FAIL retry_fill_valid c%0d got=%0b exp=%0b", k, fill_valid, k >= 5 && k <= 8); end
            checks++; if (busy !== (k >= 1 && k <= 8)) begin failures++; $display("FAIL retry_busy c%0d got=%0b exp=%0b", k, busy, k >= 1 && k <= 8); end
            if (k >= 5 && k <= 8) begin
                checks++; if (fill_line !== d) begin failures++; $display("FAIL retry_fill_line c%0d got=%h exp=%h", k, fill_line, d); end
            end
            hold_off = (k >= 5 && k <= 7);
            tick(); rd_valid = 1'b0;
        end
        hold_off = 1'b0;
        checks++; if (stat_retries !== sv(3)) begin failures++; $display("FAIL retry_count got=%0d exp=%0d", stat_retries, sv(3)); end
    endtask

    task automatic test_evict_pair();
        logic [127:0] d [2];
        do_reset();
        d[0] = rand128(); d[1] = rand128();
        req_addr = 32'h100; evict_line = d[0]; evict_wren = 1'b1;
        tick();
        req_addr = 32'h200; evict_line = d[1];
        tick();
        evict_wren = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rd_valid = 1'b1; req_addr = (j == 0) ? 32'h100 : 32'h200;
            for (int k = 0; k <= 6; k++) begin
                if (k == 5) begin
                    checks++; if (fill_valid !== 1'b1 || fill_line !== d[j]) begin failures++; $display("FAIL pair_fill%0d got=%0b/%h exp=1/%h", j, fill_valid, fill_line, d[j]); end
                end
                tick(); rd_valid = 1'b0;
            end
        end
        checks++; if (stat_evicts !== sv(2) || stat_reads !== sv(2)) begin failures++; $display("FAIL pair_stats got=%0d/%0d exp=%0d/%0d", stat_evicts, stat_reads, sv(2), sv(2)); end
    endtask

    task automatic test_write_first();
        logic [127:0] d, last;
        do_reset();
        evict(32'h40, rand128());
        tick();
        last = '0;
        // eviction in the store-read cycle itself, then one cycle earlier (still sitting in the buffer)
        for (int s = 0; s < 2; s++) begin
            d = rand128();
            rd_valid = 1'b1; req_addr = 32'h40;
            for (int k = 0; k <= 6; k++) begin
                if (k == (s == 0 ? 4 : 3)) begin evict_wren = 1'b1; req_addr = 32'h40; evict_line = d; end
                if (k == 5) begin
                    checks++; if (fill_valid !== 1'b1 || fill_line !== d) begin failures++; $display("FAIL write_first%0d got=%0b/%h exp=1/%h", s, fill_valid, fill_line, d); end
                end
                tick(); rd_valid = 1'b0; evict_wren = 1'b0;
            end
            last = d;
        end
        rd_valid = 1'b1; req_addr = 32'h40;
        for (int k = 0; k <= 6; k++) begin
            if (k == 5) begin
                checks++; if (fill_line !== last) begin failures++; $display("FAIL write_first_store got=%h exp=%h", fill_line, last); end
            end
            tick(); rd_valid = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] da, db;
        do_reset();
        da = rand128(); db = rand128();
        evict(32'h700, da);
        evict(32'h7F0, db);
        tick();
        rd_valid = 1'b1; req_addr = 32'h700;
        for (int k = 0; k <= 12; k++) begin
            if (k == 2) begin rd_valid = 1'b1; req_addr = 32'h7F0; end
            checks++; if (fill_valid !== (k == 5)) begin failures++; $display("FAIL busy_ign_fv c%0d got=%0b exp=%0b", k, fill_valid, k == 5); end
            checks++; if (busy !== (k >= 1 && k <= 5)) begin failures++; $display("FAIL busy_ign_busy c%0d got=%0b exp=%0b", k, busy, k >= 1 && k <= 5); end
            if (k == 5) begin
                checks++; if (fill_line !== da) begin failures++; $display("FAIL busy_ign_line got=%h exp=%h", fill_line, da); end
            end
            tick(); rd_valid = 1'b0;
        end
        checks++; if (stat_reads !== sv(1)) begin failures++; $display("FAIL busy_ign_reads got=%0d exp=%0d", stat_reads, sv(1)); end
    endtask

    task automatic test_reset_midread();
        logic [127:0] d, n;
        do_reset();
        d = rand128();
        evict(32'h900, d);
        tick();
        rd_valid = 1'b1; req_addr = 32'h900;
        tick(); rd_valid = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midread_busy got=%0b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || fill_valid !== 1'b0) begin failures++; $display("FAIL midread_abort got=%0b/%0b exp=0/0", busy, fill_valid); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midread_ghost c%0d got=%0b/%0b exp=0/0", k, fill_valid, busy); end
            tick();
        end
        // an eviction still in the buffer when reset hits must be discarded
        n = rand128();
        evict(32'h900, n);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_valid = 1'b1; req_addr = 32'h900;
        for (int k = 0; k <= 6; k++) begin
            checks++; if (fill_valid !== (k == 5)) begin failures++; $display("FAIL midread_new_fv c%0d got=%0b exp=%0b", k, fill_valid, k == 5); end
            if (k == 5) begin
                checks++; if (fill_line !== d) begin failures++; $display("FAIL midread_new_line got=%h exp=%h", fill_line, d); end
            end
            tick(); rd_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [127:0] mm [int];
        logic [9:0]   pool [8];
        logic [127:0] exp_fill, d;
        logic [15:0]  e_rd, e_ev, e_rt;
        logic [31:0]  a;
        logic         rd, ev, ho;
        int           phase, acc_t, rd_i, idx;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(0, 1023));
            d = rand128();
            a = $urandom; a[13:4] = pool[i];
            evict(a, d);
            mm[int'(pool[i])] = d;
        end
        e_ev = 16'd8; e_rd = '0; e_rt = '0;
        phase = 0; acc_t = 0; rd_i = 0; exp_fill = '0;
        for (int t = 0; t < 2000; t++) begin
            checks++; if (fill_valid !== (phase == 2)) begin failures++; $display("FAIL rand_fill_valid t%0d got=%0b exp=%0b", t, fill_valid, phase == 2); end
            checks++; if (busy !== (phase != 0)) begin failures++; $display("FAIL rand_busy t%0d got=%0b exp=%0b", t, busy, phase != 0); end
            checks++; if (fill_line !== exp_fill) begin failures++; $display("FAIL rand_fill_line t%0d got=%h exp=%h", t, fill_line, exp_fill); end
            checks++; if (stat_reads !== sv(e_rd) || stat_evicts !== sv(e_ev) || stat_retries !== sv(e_rt)) begin
                failures++; $display("FAIL rand_stats t%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", t, stat_reads, stat_evicts, stat_retries, sv(e_rd), sv(e_ev), sv(e_rt));
            end
            rd = ($urandom_range(0, 9) < 3);
            ev = ($urandom_range(0, 9) < 3);
            ho = $urandom_range(0, 1) == 1;
            idx = int'(pool[$urandom_range(0, 7)]);
            a = $urandom; a[13:4] = 10'(idx);
            d = rand128();
            rd_valid = rd; evict_wren = ev; hold_off = ho; req_addr = a; evict_line = d;
            // a fill returns the newest eviction to its line issued up to the store-read cycle
            if (ev) begin mm[idx] = d; e_ev++; end
            case (phase)
                0: if (rd) begin phase = 1; acc_t = t; rd_i = idx; e_rd++; end
                1: if (t == acc_t + LAT) begin exp_fill = mm[rd_i]; phase = 2; end
                default: if (ho) e_rt++; else phase = 0;
            endcase
            tick();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_evict_pair();
        test_write_first();
        test_ignore_busy();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_snoop_nexus.md
L2_SNOOP_NEXUS -- requirements
Module: l2_snoop_nexus

Interface
REQ-001 SHALL have parameter LATENCY, default 4, wait cycles between read accept and fill, legal range 1..255.
REQ-002 SHALL have parameter LINE_BITS, default 10, backing-store index width giving 2^LINE_BITS lines of 128 bits.
REQ-003 SHALL have port clk, input, 1, clock for all sequential logic, rising edge.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port rd_valid, input, 1, line-read request from the L1 on a miss.
REQ-006 SHALL have port req_addr, input, 32, line address for a read or an eviction; bits [3:0] are ignored.
REQ-007 SHALL have port evict_wren, input, 1, eviction write strobe.
REQ-008 SHALL have port evict_line, input, 128, evicted line data.
REQ-009 SHALL have port hold_off, input, 1, L1 is under hotlink interrupt and cannot accept a fill this cycle.
REQ-010 SHALL have port fill_line, output, 128, returned line data.
REQ-011 SHALL have port fill_valid, output, 1, fill_line is valid; acts as the L1 address override.
REQ-012 SHALL have port busy, output, 1, a read is in flight.
REQ-013 SHALL have ports stat_reads, stat_evicts and stat_retries, each output, 16, event counters (see Configuration).

Function
REQ-014 SHALL index the backing store by req_addr[LINE_BITS+3:4]; higher address bits alias.
REQ-015 SHALL implement the FSM states IDLE, WAIT and FILL.
REQ-016 In IDLE, rd_valid=1 SHALL latch req_addr[31:4], load cnt with LATENCY-1, and go to WAIT.
REQ-017 In WAIT, cnt SHALL decrement each cycle; at cnt=0 the FSM SHALL load fill_line from the store and go to FILL.
REQ-018 In FILL, fill_valid SHALL be 1.
REQ-019 In FILL, hold_off=0 SHALL return the FSM to IDLE.
REQ-020 In FILL, hold_off=1 SHALL keep the FSM in FILL with fill_line unchanged (retry).
REQ-021 With rd_valid at cycle 0 and hold_off low, fill_valid SHALL be high in cycle LATENCY+1 only, for exactly one cycle.
REQ-022 busy SHALL be 1 in WAIT and FILL, and 0 in IDLE.
REQ-023 rd_valid while busy SHALL be ignored, SHALL NOT be queued, and SHALL NOT perturb the in-flight read.
REQ-024 evict_wren=1 in any state SHALL capture {req_addr[31:4], evict_line} into a one-entry write buffer (wbuf) on that edge.
REQ-025 A valid wbuf SHALL be written into the store on the next edge.
REQ-026 A new eviction arriving while wbuf is valid SHALL drain the old entry and capture the new one on the same edge; evictions are never lost.
REQ-027 If the store read of REQ-017 coincides with a wbuf drain to the same index, fill_line SHALL receive the wbuf data (write-first).
REQ-028 rd_valid and evict_wren together in IDLE SHALL both be accepted; req_addr serves as both the read and the eviction address.
REQ-029 Store contents SHALL NOT be initialised by reset and are undefined until written.

Reset
REQ-030 Asserting reset at any time SHALL force the FSM to IDLE, cnt=0, wbuf invalid, fill_line=0, fill_valid=0, busy=0 and all stat_* outputs to 0.
REQ-031 Reset mid-read SHALL abort the read with no later fill pulse.
REQ-032 Reset with wbuf valid SHALL discard the pending eviction.
REQ-033 Store contents SHALL be unaffected by reset.

Configuration
REQ-034 With L2_NEXUS_STATS_EN defined, stat_reads SHALL increment on each accepted read.
REQ-035 With L2_NEXUS_STATS_EN defined, stat_evicts SHALL increment on each evict_wren.
REQ-036 With L2_NEXUS_STATS_EN defined, stat_retries SHALL increment on each FILL cycle with hold_off=1.
REQ-037 With L2_NEXUS_STATS_EN defined, all counters SHALL wrap 0xFFFF to 0x0000.
REQ-038 Without L2_NEXUS_STATS_EN, all stat_* outputs SHALL be constant 0 and no counter registers SHALL exist; all other behaviour is identical.

Verification
REQ-039 Evict addr 0x0000_1230 line 0xAAAA..AA, then rd_valid addr 0x0000_1234 at cycle 10 -> fill_valid high only in cycle 15 (LATENCY=4), fill_line=0xAAAA..AA.
REQ-040 Read pending, hold_off=1 for 3 FILL cycles -> fill_valid held 4 cycles, fill_line stable, stat_retries=3, busy drops after release.
REQ-041 Evict 0x100 then 0x200 on consecutive cycles, then read each -> fills return the respective lines, stat_evicts=2.
REQ-042 rd_valid addr 0x40 at cycle 0, evict_wren addr 0x40 data 0x5555..55 at cycle 4 (LATENCY=4, store read at cycle 4, drain at edge 5) -> fill_line=0x5555..55 via write-first.
REQ-043 rd_valid at cycle 0, second rd_valid at cycle 2 -> single fill at cycle 5 for the first address, stat_reads=1.
REQ-044 Reset asserted at cycle 3 of a read -> busy=0 and fill_valid=0 immediately; no fill ever appears; a new read then completes normally.
